// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, runs one word fetch at a time over
// req/gnt/rvalid, and presents {instr, pc, pc+4} to decode through a single-entry slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter bit          MISALIGN_CHECK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcplus4,
  output logic        instr_misaligned,
  output logic [31:0] misaligned_addr
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, FULL, HALT} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic        discard;
  logic        halt_pend;

  logic        slot_free;
  logic        consume;
  logic        redir_mis;
  logic [31:0] pc_inc;

  assign slot_free = ~if_valid | id_ready;
  assign consume   = if_valid & id_ready;
  assign redir_mis = PCSrcE & MISALIGN_CHECK & PCTargetE[1];
  assign pc_inc    = pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      pc_q             <= RESET_PC;
      discard          <= 1'b0;
      halt_pend        <= 1'b0;
      imem_req         <= 1'b0;
      imem_addr        <= RESET_PC;
      if_valid         <= 1'b0;
      if_instr         <= NOP;
      if_pc            <= '0;
      if_pcplus4       <= '0;
      instr_misaligned <= 1'b0;
      misaligned_addr  <= '0;
    end else begin
      instr_misaligned <= 1'b0;
      if (consume) if_valid <= 1'b0;

      if (PCSrcE) begin
        pc_q             <= PCTargetE;
        if_valid         <= 1'b0;
        instr_misaligned <= redir_mis;
        misaligned_addr  <= redir_mis ? PCTargetE : '0;
        if (state == REQ) begin
          // request already on the bus must stay stable until granted; its data is junk
          discard   <= 1'b1;
          halt_pend <= redir_mis;
          if (imem_gnt) begin
            imem_req <= 1'b0;
            state    <= WAIT;
          end
        end else if (state == WAIT && !imem_rvalid) begin
          discard   <= 1'b1;
          halt_pend <= redir_mis;
        end else begin
          discard   <= 1'b0;
          halt_pend <= 1'b0;
          if (redir_mis) begin
            state <= HALT;
          end else begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= PCTargetE;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc_q;
          end
          REQ: begin
            if (imem_gnt) begin
              imem_req <= 1'b0;
              state    <= WAIT;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              discard   <= 1'b0;
              halt_pend <= 1'b0;
              if (halt_pend) begin
                state <= HALT;
              end else if (!slot_free) begin
                // no room: drop the word, pc_q unchanged so it is refetched later
                state <= FULL;
              end else begin
                if (!discard) begin
                  if_valid   <= 1'b1;
                  if_instr   <= imem_rdata;
                  if_pc      <= pc_q;
                  if_pcplus4 <= pc_inc;
                  pc_q       <= pc_inc;
                end
                state     <= REQ;
                imem_req  <= 1'b1;
                imem_addr <= discard ? pc_q : pc_inc;
              end
            end
          end
          FULL: begin
            if (slot_free) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
